// File: rtl/risc_param_pkg.sv
// risc_param_pkg: opcodes, phase encoding and ALU-op classification for the parametrised RISC core
package risc_param_pkg;
  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;
  typedef enum logic [2:0] {
    INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
  } phase_t;
  function automatic logic is_aluop(input logic [2:0] op);
    return op inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
  endfunction
endpackage

// File: rtl/risc_alu_param.sv
// risc_alu_param: combinational accumulator ALU
module risc_alu_param
  import risc_param_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [2:0]            opcode,
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] result
);
  always_comb
    result = opcode == OP_ADD ? acc + rdata :
             opcode == OP_AND ? acc & rdata :
             opcode == OP_XOR ? acc ^ rdata :
             opcode == OP_LDA ? rdata : acc;
endmodule

// File: rtl/risc_core_param.sv
// risc_core_param: 8-phase accumulator CPU with HLT breakpoint, single-step and retired-instruction counter
module risc_core_param
  import risc_param_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  resume,
  input  logic                  step_mode,
  output logic                  halt,
  output logic                  zero,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [CNT_WIDTH-1:0]  instr_count
);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE  = 1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = 1;
  phase_t phase, phase_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt, ir_opr;
  logic [2:0] ir_op;
  logic [DATA_WIDTH-1:0] acc, alu_result;
  logic stepped, stepped_nxt, hlt_stop, retire;
  risc_alu_param #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .opcode(ir_op),
    .acc(acc),
    .rdata(mem_rdata),
    .result(alu_result)
  );
  assign hlt_stop    = phase == OP_ADDR && ir_op == OP_HLT;
  assign halt        = stepped || hlt_stop;
  assign zero        = acc == '0;
  assign pc_out      = pc;
  assign mem_wdata   = acc;
  assign mem_addr    = phase < OP_ADDR ? pc : ir_opr;
  assign mem_rd      = !stepped && (phase inside {INST_FETCH, INST_LOAD, IDLE} ||
                       (phase inside {OP_FETCH, ALU_OP} && is_aluop(ir_op)));
  assign mem_wr      = phase == STORE && ir_op == OP_STO;
  // A step halt parks in INST_ADDR; an HLT parks in OP_ADDR and retires on resume
  always_comb begin
    phase_nxt   = phase_t'(phase + 3'd1);
    pc_nxt      = pc;
    stepped_nxt = stepped;
    retire      = 1'b0;
    if (stepped) begin
      phase_nxt   = resume ? INST_FETCH : INST_ADDR;
      stepped_nxt = !resume;
    end else if (hlt_stop) begin
      phase_nxt = resume ? OP_FETCH : OP_ADDR;
      pc_nxt    = resume ? pc + PC_ONE : pc;
      retire    = resume;
    end else begin
      pc_nxt      = phase == OP_ADDR ? pc + PC_ONE :
                    phase == ALU_OP && ir_op == OP_SKZ && zero ? pc + PC_ONE :
                    phase inside {ALU_OP, STORE} && ir_op == OP_JMP ? ir_opr : pc;
      retire      = phase == STORE && ir_op != OP_HLT;
      stepped_nxt = phase == STORE && step_mode;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      phase       <= INST_ADDR;
      pc          <= '0;
      ir_op       <= '0;
      ir_opr      <= '0;
      acc         <= '0;
      stepped     <= 1'b0;
      instr_count <= '0;
    end else begin
      phase   <= phase_nxt;
      pc      <= pc_nxt;
      stepped <= stepped_nxt;
      if (phase == INST_LOAD) begin
        ir_op  <= mem_rdata[DATA_WIDTH-1 -: 3];
        ir_opr <= mem_rdata[ADDR_WIDTH-1:0];
      end
      if (phase == STORE && is_aluop(ir_op)) acc <= alu_result;
      if (retire && !(&instr_count)) instr_count <= instr_count + CNT_ONE;
    end
endmodule
